// File: rtl/ef_spi_target.sv
// ef_spi_target: SPI target endpoint clocked entirely by clk.
//   sclk/csb/mosi are synchronized (2 flops) and edge-detected against a third
//   flop; all four CPOL/CPHA modes, MSB-first 8-bit bytes.
// Ports:
//   clk, rst            system clock, async active-high reset
//   enable              0 holds the bus engine IDLE
//   CPOL, CPHA          SPI mode
//   rx_en               store completed bytes in the RX FIFO
//   wr, datai           TX FIFO push
//   rd, datao           RX FIFO pop / show-ahead head
//   rx_flush, tx_flush  FIFO flush
//   rx_/tx_ empty/full/level  FIFO status
//   rx_overrun          1-cycle pulse: completed byte dropped, RX full
//   tx_underrun         1-cycle pulse: byte load found TX empty
//   busy, miso_oe       frame active
//   sclk, csb, mosi     SPI bus in; miso SPI data out

module ef_spi_target_fifo #(
  parameter int unsigned FAW = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  logic [7:0]   din,
  output logic [7:0]   head,
  output logic         empty,
  output logic         full,
  output logic [FAW:0] level
);
  localparam int unsigned DEPTH = 1 << FAW;

  logic [7:0]     mem [DEPTH];
  logic [FAW-1:0] wp;
  logic [FAW-1:0] rp;
  logic           do_push;
  logic           do_pop;

  assign empty   = (level == '0);
  assign full    = level[FAW];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = empty ? '0 : mem[rp];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp    <= '0;
      rp    <= '0;
      level <= '0;
    end else if (flush) begin
      wp    <= '0;
      rp    <= '0;
      level <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop)  rp <= rp + 1'b1;
      if (do_push && !do_pop)      level <= level + 1'b1;
      else if (do_pop && !do_push) level <= level - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wp] <= din;
  end
endmodule

module ef_spi_target #(
  parameter int unsigned FAW = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         enable,
  input  logic         CPOL,
  input  logic         CPHA,
  input  logic         rx_en,
  input  logic         wr,
  input  logic [7:0]   datai,
  input  logic         rd,
  output logic [7:0]   datao,
  input  logic         rx_flush,
  input  logic         tx_flush,
  output logic         rx_empty,
  output logic         rx_full,
  output logic         tx_empty,
  output logic         tx_full,
  output logic [FAW:0] rx_level,
  output logic [FAW:0] tx_level,
  output logic         rx_overrun,
  output logic         tx_underrun,
  output logic         busy,
  input  logic         sclk,
  input  logic         csb,
  input  logic         mosi,
  output logic         miso,
  output logic         miso_oe
);
  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t     state;
  state_t     state_nxt;
  logic       sclk_s1, sclk_s2, sclk_s3;
  logic       csb_s1, csb_s2, csb_s3;
  logic       mosi_s1, mosi_s2;
  logic       sclk_rise, sclk_fall, csb_fall, csb_rise;
  logic       lead_edge, trail_edge, sample_edge, shift_edge;
  logic       stay_active, entry, do_sample, do_shift, load;
  logic [7:0] tx_sr;
  logic [6:0] rx_sr;
  logic [2:0] bit_cnt;
  logic       rx_push;
  logic [7:0] rx_byte;
  logic [7:0] tx_head;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_s1 <= 1'b0; sclk_s2 <= 1'b0; sclk_s3 <= 1'b0;
      csb_s1  <= 1'b1; csb_s2  <= 1'b1; csb_s3  <= 1'b1;
      mosi_s1 <= 1'b0; mosi_s2 <= 1'b0;
    end else begin
      sclk_s1 <= sclk; sclk_s2 <= sclk_s1; sclk_s3 <= sclk_s2;
      csb_s1  <= csb;  csb_s2  <= csb_s1;  csb_s3  <= csb_s2;
      mosi_s1 <= mosi; mosi_s2 <= mosi_s1;
    end
  end

  assign sclk_rise   = sclk_s2 & ~sclk_s3;
  assign sclk_fall   = ~sclk_s2 & sclk_s3;
  assign csb_fall    = ~csb_s2 & csb_s3;
  assign csb_rise    = csb_s2 & ~csb_s3;
  assign lead_edge   = CPOL ? sclk_fall : sclk_rise;
  assign trail_edge  = CPOL ? sclk_rise : sclk_fall;
  assign sample_edge = CPHA ? trail_edge : lead_edge;
  assign shift_edge  = CPHA ? lead_edge : trail_edge;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (enable && csb_fall) state_nxt = ACTIVE;
      ACTIVE:  if (csb_rise || !enable) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign stay_active = (state == ACTIVE) && (state_nxt == ACTIVE);
  assign entry       = (state == IDLE) && (state_nxt == ACTIVE);
  assign do_sample   = stay_active & sample_edge;
  assign do_shift    = stay_active & shift_edge;
  // Both modes load on the first shift edge seen with the counter at 0; for
  // CPHA=0 that is the edge right after the 8th sample, and the first byte
  // of a CPHA=0 frame is loaded on entry instead.
  assign load        = (entry & ~CPHA) | (do_shift & (bit_cnt == 3'd0));

  assign rx_byte = {rx_sr, mosi_s2};
  assign rx_push = do_sample & (bit_cnt == 3'd7) & rx_en;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_sr       <= '0;
      rx_sr       <= '0;
      bit_cnt     <= '0;
      tx_underrun <= 1'b0;
      rx_overrun  <= 1'b0;
    end else begin
      tx_underrun <= load & tx_empty;
      rx_overrun  <= rx_push & rx_full;
      // FIFO head reads 0x00 when empty, which is the underrun fill byte.
      if (load)          tx_sr <= tx_head;
      else if (do_shift) tx_sr <= {tx_sr[6:0], 1'b0};
      if (state_nxt == IDLE) begin
        bit_cnt <= '0;
      end else if (do_sample) begin
        rx_sr   <= {rx_sr[5:0], mosi_s2};
        bit_cnt <= bit_cnt + 1'b1;
      end
    end
  end

  ef_spi_target_fifo #(.FAW(FAW)) u_tx_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (tx_flush),
    .push  (wr),
    .pop   (load),
    .din   (datai),
    .head  (tx_head),
    .empty (tx_empty),
    .full  (tx_full),
    .level (tx_level)
  );

  ef_spi_target_fifo #(.FAW(FAW)) u_rx_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (rx_flush),
    .push  (rx_push),
    .pop   (rd),
    .din   (rx_byte),
    .head  (datao),
    .empty (rx_empty),
    .full  (rx_full),
    .level (rx_level)
  );

  assign busy    = (state == ACTIVE);
  assign miso_oe = (state == ACTIVE);
  assign miso    = tx_sr[7];
endmodule

// File: tb/tb_ef_spi_target.sv
module tb_ef_spi_target;
  localparam int HALF = 8;

  logic       clk, rst, enable, CPOL, CPHA, rx_en, wr, rd, rx_flush, tx_flush;
  logic [7:0] datai, datao;
  logic       rx_empty, rx_full, tx_empty, tx_full, rx_overrun, tx_underrun, busy;
  logic [4:0] rx_level, tx_level;
  logic       sclk, csb, mosi, miso, miso_oe;

  int checks = 0;
  int errors = 0;
  int ur_cnt = 0;
  int or_cnt = 0;
  logic       busy_seen;
  logic [7:0] m_out [0:15];
  logic [7:0] m_in  [0:15];

  ef_spi_target #(.FAW(4)) dut (
    .clk(clk), .rst(rst), .enable(enable), .CPOL(CPOL), .CPHA(CPHA),
    .rx_en(rx_en), .wr(wr), .datai(datai), .rd(rd), .datao(datao),
    .rx_flush(rx_flush), .tx_flush(tx_flush), .rx_empty(rx_empty),
    .rx_full(rx_full), .tx_empty(tx_empty), .tx_full(tx_full),
    .rx_level(rx_level), .tx_level(tx_level), .rx_overrun(rx_overrun),
    .tx_underrun(tx_underrun), .busy(busy), .sclk(sclk), .csb(csb),
    .mosi(mosi), .miso(miso), .miso_oe(miso_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counts high cycles, so a pulse longer than one cycle shows up as extra.
  always @(posedge clk) begin
    if (tx_underrun) ur_cnt++;
    if (rx_overrun)  or_cnt++;
  end

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic tx_push(input logic [7:0] d);
    datai = d; wr = 1'b1;
    wait_clks(1);
    wr = 1'b0;
  endtask

  task automatic rx_pop();
    rd = 1'b1;
    wait_clks(1);
    rd = 1'b0;
  endtask

  task automatic set_mode(input logic pol, input logic pha);
    CPOL = pol; CPHA = pha; sclk = pol;
    wait_clks(HALF);
  endtask

  task automatic spi_bits(input int nbits);
    for (int i = 0; i < nbits; i++) begin
      logic [7:0] ob;
      ob = m_out[i / 8];
      if (!CPHA) begin
        mosi = ob[7 - (i % 8)];
        wait_clks(HALF);
        m_in[i / 8][7 - (i % 8)] = miso;
        sclk = ~CPOL;
        wait_clks(HALF);
        sclk = CPOL;
      end else begin
        sclk = ~CPOL;
        mosi = ob[7 - (i % 8)];
        wait_clks(HALF);
        m_in[i / 8][7 - (i % 8)] = miso;
        sclk = CPOL;
        wait_clks(HALF);
      end
    end
  endtask

  task automatic spi_frame(input int nbits);
    for (int i = 0; i < 16; i++) m_in[i] = 8'h00;
    csb = 1'b0;
    wait_clks(HALF);
    busy_seen = busy & miso_oe;
    spi_bits(nbits);
    wait_clks(HALF);
    csb = 1'b1;
    wait_clks(HALF);
  endtask

  task automatic test_reset();
    checks++; if (busy !== 1'b0 || miso_oe !== 1'b0) begin errors++; $display("FAIL reset_busy got %b%b want 00", busy, miso_oe); end
    checks++; if (rx_empty !== 1'b1 || tx_empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b%b want 11", rx_empty, tx_empty); end
    checks++; if (rx_full !== 1'b0 || tx_full !== 1'b0) begin errors++; $display("FAIL reset_full got %b%b want 00", rx_full, tx_full); end
    checks++; if (rx_level !== 5'd0 || tx_level !== 5'd0) begin errors++; $display("FAIL reset_level got %0d %0d want 0 0", rx_level, tx_level); end
    checks++; if (datao !== 8'h00 || miso !== 1'b0) begin errors++; $display("FAIL reset_data got %h %b want 00 0", datao, miso); end
    checks++; if (tx_underrun !== 1'b0 || rx_overrun !== 1'b0) begin errors++; $display("FAIL reset_pulses got %b%b want 00", tx_underrun, rx_overrun); end
  endtask

  task automatic test_tx_fifo();
    for (int i = 0; i < 17; i++) tx_push(8'h30 + 8'(i));
    checks++; if (tx_full !== 1'b1 || tx_level !== 5'd16) begin errors++; $display("FAIL txf_full got %b %0d want 1 16", tx_full, tx_level); end
    tx_flush = 1'b1; datai = 8'h99; wr = 1'b1;
    wait_clks(1);
    tx_flush = 1'b0; wr = 1'b0;
    checks++; if (tx_level !== 5'd0 || tx_empty !== 1'b1) begin errors++; $display("FAIL txf_flush got %0d %b want 0 1", tx_level, tx_empty); end
  endtask

  task automatic test_mode0();
    int ur0;
    set_mode(1'b0, 1'b0);
    tx_push(8'hA5);
    checks++; if (tx_level !== 5'd1) begin errors++; $display("FAIL m0_txlvl_pre got %0d want 1", tx_level); end
    ur0 = ur_cnt;
    m_out[0] = 8'h3C;
    spi_frame(8);
    checks++; if (busy_seen !== 1'b1) begin errors++; $display("FAIL m0_busy_mid got %b want 1", busy_seen); end
    checks++; if (m_in[0] !== 8'hA5) begin errors++; $display("FAIL m0_miso got %h want a5", m_in[0]); end
    checks++; if (datao !== 8'h3C || rx_level !== 5'd1) begin errors++; $display("FAIL m0_rx got %h %0d want 3c 1", datao, rx_level); end
    checks++; if (tx_level !== 5'd0) begin errors++; $display("FAIL m0_txlvl got %0d want 0", tx_level); end
    // Load after the 8th sample finds TX empty.
    checks++; if (ur_cnt - ur0 !== 1) begin errors++; $display("FAIL m0_underrun got %0d want 1", ur_cnt - ur0); end
    checks++; if (busy !== 1'b0 || miso_oe !== 1'b0) begin errors++; $display("FAIL m0_idle got %b%b want 00", busy, miso_oe); end
    rx_pop();
    checks++; if (rx_empty !== 1'b1 || datao !== 8'h00) begin errors++; $display("FAIL m0_pop got %b %h want 1 00", rx_empty, datao); end
  endtask

  task automatic test_modes();
    for (int m = 1; m < 4; m++) begin
      set_mode(m[1], m[0]);
      tx_push(8'h81);
      m_out[0] = 8'h7E;
      spi_frame(8);
      checks++; if (m_in[0] !== 8'h81) begin errors++; $display("FAIL mode%0d_miso got %h want 81", m, m_in[0]); end
      checks++; if (datao !== 8'h7E || rx_level !== 5'd1) begin errors++; $display("FAIL mode%0d_rx got %h %0d want 7e 1", m, datao, rx_level); end
      rx_pop();
    end
  endtask

  task automatic test_multibyte();
    int ur0;
    set_mode(1'b0, 1'b1);
    tx_push(8'h11); tx_push(8'h22);
    m_out[0] = 8'hC3; m_out[1] = 8'h5A; m_out[2] = 8'h96;
    ur0 = ur_cnt;
    spi_frame(24);
    checks++; if (m_in[0] !== 8'h11 || m_in[1] !== 8'h22 || m_in[2] !== 8'h00) begin errors++; $display("FAIL mb_miso got %h %h %h want 11 22 00", m_in[0], m_in[1], m_in[2]); end
    checks++; if (ur_cnt - ur0 !== 1) begin errors++; $display("FAIL mb_underrun got %0d want 1", ur_cnt - ur0); end
    checks++; if (rx_level !== 5'd3) begin errors++; $display("FAIL mb_rxlvl got %0d want 3", rx_level); end
    checks++; if (datao !== 8'hC3) begin errors++; $display("FAIL mb_rx0 got %h want c3", datao); end
    rx_pop();
    checks++; if (datao !== 8'h5A) begin errors++; $display("FAIL mb_rx1 got %h want 5a", datao); end
    rx_pop();
    checks++; if (datao !== 8'h96) begin errors++; $display("FAIL mb_rx2 got %h want 96", datao); end
    rx_pop();
  endtask

  task automatic test_abort();
    set_mode(1'b0, 1'b1);
    tx_push(8'h4D); tx_push(8'hB2);
    m_out[0] = 8'hFF;
    spi_frame(5);
    checks++; if (m_in[0][7:3] !== 5'b01001) begin errors++; $display("FAIL ab_miso got %b want 01001", m_in[0][7:3]); end
    checks++; if (rx_level !== 5'd0 || rx_empty !== 1'b1) begin errors++; $display("FAIL ab_norx got %0d %b want 0 1", rx_level, rx_empty); end
    checks++; if (busy !== 1'b0 || miso_oe !== 1'b0) begin errors++; $display("FAIL ab_idle got %b%b want 00", busy, miso_oe); end
    checks++; if (tx_level !== 5'd1) begin errors++; $display("FAIL ab_txlvl got %0d want 1", tx_level); end
    m_out[0] = 8'h69;
    spi_frame(8);
    checks++; if (m_in[0] !== 8'hB2) begin errors++; $display("FAIL ab_next_miso got %h want b2", m_in[0]); end
    checks++; if (datao !== 8'h69 || rx_level !== 5'd1) begin errors++; $display("FAIL ab_next_rx got %h %0d want 69 1", datao, rx_level); end
    rx_pop();
  endtask

  task automatic test_overflow();
    int or0;
    set_mode(1'b0, 1'b0);
    for (int i = 0; i < 16; i++) m_out[i] = 8'h10 + 8'(i);
    or0 = or_cnt;
    spi_frame(128);
    checks++; if (rx_full !== 1'b1 || rx_level !== 5'd16) begin errors++; $display("FAIL of_fill got %b %0d want 1 16", rx_full, rx_level); end
    checks++; if (or_cnt - or0 !== 0) begin errors++; $display("FAIL of_fill_overrun got %0d want 0", or_cnt - or0); end
    m_out[0] = 8'hEE;
    spi_frame(8);
    checks++; if (or_cnt - or0 !== 1) begin errors++; $display("FAIL of_overrun got %0d want 1", or_cnt - or0); end
    checks++; if (rx_level !== 5'd16 || datao !== 8'h10) begin errors++; $display("FAIL of_kept got %0d %h want 16 10", rx_level, datao); end
    rd = 1'b1; rx_flush = 1'b1;
    wait_clks(1);
    rd = 1'b0; rx_flush = 1'b0;
    checks++; if (rx_level !== 5'd0 || rx_empty !== 1'b1) begin errors++; $display("FAIL of_flush got %0d %b want 0 1", rx_level, rx_empty); end
  endtask

  task automatic test_reset_midframe();
    set_mode(1'b0, 1'b0);
    tx_flush = 1'b1; wait_clks(1); tx_flush = 1'b0;
    tx_push(8'h5A); tx_push(8'h6B); tx_push(8'h7C);
    m_out[0] = 8'hF0; m_out[1] = 8'h0F;
    csb = 1'b0;
    wait_clks(HALF);
    spi_bits(10);
    checks++; if (busy !== 1'b1 || rx_level !== 5'd1 || tx_level !== 5'd1 || miso !== 1'b1) begin errors++; $display("FAIL rm_pre got %b %0d %0d %b want 1 1 1 1", busy, rx_level, tx_level, miso); end
    #1 rst = 1'b1;
    #1;
    checks++; if (busy !== 1'b0 || miso_oe !== 1'b0 || miso !== 1'b0) begin errors++; $display("FAIL rm_bus got %b%b%b want 000", busy, miso_oe, miso); end
    checks++; if (rx_level !== 5'd0 || tx_level !== 5'd0 || rx_empty !== 1'b1 || tx_empty !== 1'b1) begin errors++; $display("FAIL rm_fifo got %0d %0d %b%b want 0 0 11", rx_level, tx_level, rx_empty, tx_empty); end
    checks++; if (datao !== 8'h00) begin errors++; $display("FAIL rm_datao got %h want 00", datao); end
    csb = 1'b1; sclk = 1'b0; mosi = 1'b0;
    wait_clks(2);
    rst = 1'b0;
    wait_clks(HALF);
    checks++; if (busy !== 1'b0 || tx_underrun !== 1'b0) begin errors++; $display("FAIL rm_after got %b %b want 0 0", busy, tx_underrun); end
  endtask

  initial begin
    rst = 1'b1; enable = 1'b1; CPOL = 1'b0; CPHA = 1'b0; rx_en = 1'b1;
    wr = 1'b0; datai = 8'h00; rd = 1'b0; rx_flush = 1'b0; tx_flush = 1'b0;
    sclk = 1'b0; csb = 1'b1; mosi = 1'b0;
    for (int i = 0; i < 16; i++) begin m_out[i] = 8'h00; m_in[i] = 8'h00; end
    busy_seen = 1'b0;
    wait_clks(3);
    rst = 1'b0;
    wait_clks(3);
    test_reset();
    test_tx_fifo();
    test_mode0();
    test_modes();
    test_multibyte();
    test_abort();
    test_overflow();
    test_reset_midframe();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
